myproject_mul_share_rr: RTL and testbench
=========================================

# myproject_mul_share_rr

Round-robin scheduler that time-shares one combinational 12s x 8s -> 20-bit multiplier instance among N_REQ requesters. It arbitrates operand requests, registers the granted operands into the multiplier, captures the product and returns it with the requester index over a valid/ready response port. It sits between the dense-layer reuse loops and the shared multiplier instance. It exists so that layers with reuse factor > 1 can map several product terms onto one DSP.

## Interface
- N_REQ, 4, number of requesters (2..8)
- ID_W, 2, requester index width, clog2(N_REQ)
- DIN0_W, 12, signed operand A width
- DIN1_W, 8, signed operand B width
- DOUT_W, 20, signed product width (= DIN0_W + DIN1_W)

Ports:
- ap_clk  in  1  clock; all state updates on the rising edge
- ap_rst  in  1  reset, asynchronous, active-high
- req_valid  in  N_REQ  per-requester operand valid
- req_ready  out  N_REQ  per-requester grant; one-hot or zero
- req_a  in  N_REQ*DIN0_W  operand A, requester i at bits [i*DIN0_W +: DIN0_W]
- req_b  in  N_REQ*DIN1_W  operand B, requester i at bits [i*DIN1_W +: DIN1_W]
- mul_din0  out  DIN0_W  operand A to the shared multiplier (S1 register)
- mul_din1  out  DIN1_W  operand B to the shared multiplier (S1 register)
- mul_dout  in  DOUT_W  combinational product from the shared multiplier
- rsp_valid  out  1  result valid (S2)
- rsp_ready  in  1  result consumer ready
- rsp_data  out  DOUT_W  signed product
- rsp_id  out  ID_W  index of the requester that owns rsp_data

## Operation
- The pipeline has two register stages:
  - S1 holds s1_valid, s1_id, and the operand registers that drive mul_din0 and mul_din1.
  - S2 holds rsp_valid, rsp_id and rsp_data.
- S2 advance: s2_adv = !rsp_valid || rsp_ready.
  - If s2_adv is true, S2 loads s1_valid, s1_id and mul_dout.
  - If s2_adv is false, S2 holds.
- S1 load: s1_adv = !s1_valid || s2_adv.
  - If s1_adv is true, S1 loads the granted request, or loads s1_valid=0 when there is no grant.
  - Operand registers load only on a grant and otherwise hold their last value.
- Arbitration is combinational.
  - When s1_adv=1, req_ready[i]=1 for the first i with req_valid[i]=1, searching from ptr upward and wrapping modulo N_REQ.
  - When s1_adv=0, req_ready is all-zero.
  - req_ready may depend on req_valid in the same cycle. Requesters must not make req_valid depend on req_ready.
- Pointer: on a grant to index g, ptr <= (g+1) mod N_REQ. With no grant, ptr holds.
- Handshake: a transfer occurs on an edge where req_valid[i] && req_ready[i]. Requesters hold req_valid, req_a and req_b stable until that transfer.
- Arithmetic: rsp_data = signed(a) * signed(b) at full width, with no truncation or saturation.
  - Range is -262016..+262144, which fits in 20 bits signed.
  - The multiplier itself is external. This block adds no arithmetic.
- Capacity: at most 2 results are in flight (S1 + S2). When both stages are full and rsp_ready=0, all req_ready are 0.
- Responses leave in grant order, so no reordering is needed.

## Timing
- Reset values while ap_rst=1, taking effect immediately:
  - s1_valid=0, rsp_valid=0, rsp_data=0, rsp_id=0, ptr=0.
  - mul_din0=0, mul_din1=0.
  - req_ready=0 during reset.
- Reset mid-operation drops all in-flight operations silently. No response is emitted for them.
- Latency: a request accepted at edge k produces rsp_valid=1 after edge k+1, provided rsp_ready was not low on edge k+1 while S2 was occupied.
- Throughput: one result per cycle with rsp_ready held high and at least one requester valid.
- rsp_valid, rsp_data and rsp_id stay stable while rsp_valid=1 && rsp_ready=0.
- A response pop and a new accept on the same edge are both legal and both occur:
  - S2 pops.
  - S1 moves to S2.
  - The new request enters S1.
- Fairness: any requester held valid is granted within N_REQ accepts.

## Test plan
- Single request, requester 2, a=-2048 (0x800), b=-128 (0x80), accepted at edge 0 → rsp_valid=1 after edge 1 with rsp_data=0x40000 (+262144) and rsp_id=2. Also check a=2047, b=-128 → rsp_data=-262016 (0xC0080).
- All 4 requesters valid continuously with rsp_ready=1 → grant order 0,1,2,3,0,1,…, one grant per cycle, rsp_id sequence matches the grant order delayed by 2 cycles.
- Backpressure:
  - rsp_ready=0 for 5 cycles while requester 0 is valid → exactly 2 accepts, then req_ready=0 and S2 held stable.
  - After rsp_ready returns to 1 → results drain in order, accepts resume the same cycle, no loss or duplication.
- Pointer wrap: only requesters 1 and 3 valid starting at ptr=2 → grants 3,1,3,1. After a grant to 3, ptr=0. Requester 0 asserting later is granted next if ptr=0.
- Reset mid-stream: assert ap_rst asynchronously between edges with S1 and S2 full → rsp_valid, s1_valid, ptr and the mul_din outputs go to 0 at once. After release, the first accepted request is served by the priority rule from ptr=0.
- Random stress: random req_valid per requester and random rsp_ready over 10k cycles, checked against a reference queue model of the signed product, rsp_id, order and the per-requester starvation bound.

Source files
------------

// File: rtl/myproject_mul_share_rr.sv
// Round-robin time-sharing of one external signed multiplier among N_REQ
// requesters. Two register stages: S1 holds the granted operands that feed
// the multiplier, S2 captures the product and presents it on the response port.
module myproject_mul_share_rr #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned ID_W   = 2,
  parameter int unsigned DIN0_W = 12,
  parameter int unsigned DIN1_W = 8,
  parameter int unsigned DOUT_W = 20
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ*DIN0_W-1:0]  req_a,
  input  logic [N_REQ*DIN1_W-1:0]  req_b,
  output logic [DIN0_W-1:0]        mul_din0,
  output logic [DIN1_W-1:0]        mul_din1,
  input  logic [DOUT_W-1:0]        mul_dout,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DOUT_W-1:0]        rsp_data,
  output logic [ID_W-1:0]          rsp_id
);

  logic            s1_valid;
  logic [ID_W-1:0] s1_id;
  logic [ID_W-1:0] ptr;
  logic            s2_adv;
  logic            s1_adv;
  logic            gnt_found;
  logic [ID_W-1:0] gnt_id;
  logic [ID_W-1:0] cand;
  logic            grant;

  assign s2_adv = !rsp_valid || rsp_ready;
  assign s1_adv = !s1_valid || s2_adv;
  // Reset gating keeps req_ready low while ap_rst is held, even though S1 is empty then.
  assign grant  = s1_adv && gnt_found && !ap_rst;

  // Round-robin search starting at ptr, wrapping modulo N_REQ
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    cand      = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = ID_W'((32'(ptr) + k) % N_REQ);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_id    = cand;
      end
    end
  end

  // One-hot grant to the selected requester when S1 can accept
  always_comb begin
    req_ready = '0;
    if (grant) req_ready[gnt_id] = 1'b1;
  end

  // Pipeline registers, operand capture and round-robin pointer update
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      s1_valid  <= 1'b0;
      s1_id     <= '0;
      ptr       <= '0;
      mul_din0  <= '0;
      mul_din1  <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
    end else begin
      if (s2_adv) begin
        rsp_valid <= s1_valid;
        rsp_id    <= s1_id;
        rsp_data  <= mul_dout;
      end
      if (s1_adv) begin
        s1_valid <= gnt_found;
        if (gnt_found) begin
          s1_id    <= gnt_id;
          mul_din0 <= req_a[gnt_id*DIN0_W +: DIN0_W];
          mul_din1 <= req_b[gnt_id*DIN1_W +: DIN1_W];
          ptr      <= (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_myproject_mul_share_rr.sv
// Bench for myproject_mul_share_rr: directed steps plus random stress,
// with a queue scoreboard of expected products and requester ids.
module tb_myproject_mul_share_rr;

  localparam int N  = 4;
  localparam int IW = 2;
  localparam int AW = 12;
  localparam int BW = 8;
  localparam int DW = 20;

  logic                 ap_clk = 1'b0;
  logic                 ap_rst = 1'b0;
  logic [N-1:0]         req_valid;
  logic [N-1:0]         req_ready;
  logic [N*AW-1:0]      req_a;
  logic [N*BW-1:0]      req_b;
  logic [AW-1:0]        mul_din0;
  logic [BW-1:0]        mul_din1;
  logic signed [DW-1:0] mul_dout;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [DW-1:0]        rsp_data;
  logic [IW-1:0]        rsp_id;

  // External shared multiplier
  assign mul_dout = $signed(mul_din0) * $signed(mul_din1);

  myproject_mul_share_rr #(.N_REQ(N), .ID_W(IW), .DIN0_W(AW), .DIN1_W(BW), .DOUT_W(DW)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .mul_din0(mul_din0), .mul_din1(mul_din1), .mul_dout(mul_dout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    logic [DW-1:0] data;
    logic [IW-1:0] id;
  } exp_t;

  exp_t          sbq[$];
  int            gseq[$];
  int            tests = 0;
  int            fails = 0;
  logic          m1, m2;
  logic [IW-1:0] mptr;
  logic [N-1:0]  acc;
  int            waitc[N];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample at the falling edge, compare against the reference model, advance it
  task automatic cycle();
    logic         s2a, s1a, found;
    logic [IW-1:0] g;
    logic [N-1:0] er;
    exp_t         e;
    @(negedge ap_clk);
    s2a   = !m2 || rsp_ready;
    s1a   = !m1 || s2a;
    found = 1'b0;
    g     = '0;
    for (int k = 0; k < N; k++) begin
      int idx = (int'(mptr) + k) % N;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        g     = IW'(idx);
      end
    end
    er = '0;
    if (s1a && found) er[g] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(er));
    check("rsp_valid", 32'(rsp_valid), 32'(m2));
    if (m2 && sbq.size() > 0) begin
      check("rsp_data", 32'(rsp_data), 32'(sbq[0].data));
      check("rsp_id", 32'(rsp_id), 32'(sbq[0].id));
      if (rsp_ready) void'(sbq.pop_front());
    end
    acc = '0;
    if (s1a && found) begin
      e.data = DW'(int'($signed(req_a[g*AW +: AW])) * int'($signed(req_b[g*BW +: BW])));
      e.id   = g;
      sbq.push_back(e);
      gseq.push_back(int'(g));
      acc[g] = 1'b1;
      for (int i = 0; i < N; i++) begin
        if (i != int'(g) && req_valid[i]) begin
          waitc[i]++;
          check("starve_bound", 32'(waitc[i] <= N - 1), 32'd1);
        end
      end
      waitc[g] = 0;
      mptr = (int'(g) == N - 1) ? '0 : g + 1'b1;
    end
    for (int i = 0; i < N; i++) if (!req_valid[i]) waitc[i] = 0;
    m2 = s2a ? m1 : m2;
    m1 = s1a ? found : m1;
    @(posedge ap_clk);
    #1;
  endtask

  // Requesters: hold until transfer, then present fresh operands if still wanted
  task automatic drive(input logic [N-1:0] want);
    for (int i = 0; i < N; i++) begin
      if (acc[i] || !req_valid[i]) begin
        if (want[i]) begin
          req_valid[i]          = 1'b1;
          req_a[i*AW +: AW]     = AW'($urandom);
          req_b[i*BW +: BW]     = BW'($urandom);
        end else begin
          req_valid[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic drain();
    rsp_ready = 1'b1;
    for (int n = 0; n < 30 && (sbq.size() != 0 || req_valid != '0); n++) begin
      drive('0);
      cycle();
    end
    check("drained", 32'(sbq.size()), 32'd0);
  endtask

  // Asynchronous reset between edges; outputs must clear immediately
  task automatic pulse_reset();
    #2;
    ap_rst = 1'b1;
    #1;
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_s1_valid", 32'(dut.s1_valid), 32'd0);
    check("rst_ptr", 32'(dut.ptr), 32'd0);
    check("rst_din0", 32'(mul_din0), 32'd0);
    check("rst_din1", 32'(mul_din1), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    sbq.delete();
    m1 = 1'b0; m2 = 1'b0; mptr = '0; acc = '0;
    for (int i = 0; i < N; i++) waitc[i] = 0;
    req_valid = '0;
    ap_rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int exp_wrap[7];
    logic [DW-1:0] held;
    exp_wrap = '{1, 3, 1, 3, 1, 3, 0};
    ap_rst = 1'b1;
    req_valid = '1;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b1;
    m1 = 1'b0; m2 = 1'b0; mptr = '0; acc = '0;
    for (int i = 0; i < N; i++) waitc[i] = 0;
    #2;
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_data", 32'(rsp_data), 32'd0);
    check("reset_rsp_id", 32'(rsp_id), 32'd0);
    check("reset_din0", 32'(mul_din0), 32'd0);
    check("reset_din1", 32'(mul_din1), 32'd0);
    check("reset_req_ready", 32'(req_ready), 32'd0);
    @(posedge ap_clk);
    #1;
    req_valid = '0;
    ap_rst = 1'b0;

    // Extreme products: -2048 * -128 and 2047 * -128
    req_valid = 4'b0100;
    req_a[2*AW +: AW] = 12'h800;
    req_b[2*BW +: BW] = 8'h80;
    cycle();
    check("lat_s1_only", 32'(rsp_valid), 32'd0);
    req_valid = '0;
    cycle();
    check("max_pos_valid", 32'(rsp_valid), 32'd1);
    check("max_pos_data", 32'(rsp_data), 32'h40000);
    check("max_pos_id", 32'(rsp_id), 32'd2);
    req_valid = 4'b0100;
    req_a[2*AW +: AW] = 12'd2047;
    req_b[2*BW +: BW] = 8'h80;
    cycle();
    req_valid = '0;
    cycle();
    check("max_neg_valid", 32'(rsp_valid), 32'd1);
    check("max_neg_data", 32'(rsp_data), 32'hC0080);
    drain();

    // All requesters valid: strict rotation from ptr=0
    pulse_reset();
    gseq.delete();
    repeat (12) begin
      drive('1);
      cycle();
    end
    check("rr_count", 32'(gseq.size()), 32'd12);
    for (int i = 0; i < 12 && i < gseq.size(); i++) check("rr_order", 32'(gseq[i]), 32'(i % 4));
    drain();

    // Backpressure: only two accepts fit, S2 holds stable
    rsp_ready = 1'b0;
    n0 = gseq.size();
    repeat (3) begin
      drive(4'b0001);
      cycle();
    end
    held = rsp_data;
    repeat (2) begin
      drive(4'b0001);
      cycle();
    end
    check("bp_accepts", 32'(gseq.size() - n0), 32'd2);
    check("bp_ready_low", 32'(req_ready), 32'd0);
    check("bp_hold", 32'(rsp_data), 32'(held));
    rsp_ready = 1'b1;
    repeat (4) begin
      drive(4'b0001);
      cycle();
    end
    drain();

    // Pointer wrap with requesters 1 and 3, then requester 0 after wrap
    pulse_reset();
    gseq.delete();
    drive(4'b0010);
    cycle();
    repeat (5) begin
      drive(4'b1010);
      cycle();
    end
    check("wrap_ptr", 32'(dut.ptr), 32'd0);
    drive(4'b0011);
    cycle();
    check("wrap_count", 32'(gseq.size()), 32'd7);
    for (int i = 0; i < 7 && i < gseq.size(); i++) check("wrap_order", 32'(gseq[i]), 32'(exp_wrap[i]));
    drain();

    // Reset with both stages full
    rsp_ready = 1'b0;
    repeat (2) begin
      drive('1);
      cycle();
    end
    check("full_s1", 32'(dut.s1_valid), 32'd1);
    check("full_s2", 32'(rsp_valid), 32'd1);
    pulse_reset();
    rsp_ready = 1'b1;
    gseq.delete();
    drive(4'b1010);
    cycle();
    check("post_rst_grant", 32'(gseq.size() > 0 ? gseq[0] : -1), 32'd1);
    drain();

    // Random stress
    repeat (10000) begin
      rsp_ready = ($urandom_range(0, 3) != 0);
      drive(N'($urandom));
      cycle();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
